alu_datapath: RTL and testbench
===============================

ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 16, result width in bits (fixed at 16 for this revision).
REQ-002 SHALL have parameter OP_W, default 4, opcode width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  level request from controller; high = execute operation on opcode/a/b.
REQ-006 SHALL have port opcode  input  OP_W  operation select.
REQ-007 SHALL have port a  input  8  unsigned operand A.
REQ-008 SHALL have port b  input  8  unsigned operand B.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse; result/error valid while high.
REQ-010 SHALL have port result  output  WIDTH  registered operation result.
REQ-011 SHALL have port error  output  1  registered error flag (invalid opcode or divide-by-zero), qualified by done.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, EXEC, DONE, RELEASE.
REQ-014 IDLE: on rising edge with enable=1, SHALL capture opcode, a, b into internal registers, clear iteration counter, go to EXEC; enable=0 stays IDLE.
REQ-015 Operands/opcode SHALL be used only from captured registers; input changes after capture SHALL have no effect.
REQ-016 Opcode 0 (ADD): result = {7'b0, a+b} (9-bit sum zero-extended); EXEC lasts 1 cycle.
REQ-017 Opcode 1 (SUB): result = 16-bit two's complement of ({8'b0,a} - {8'b0,b}); EXEC lasts 1 cycle.
REQ-018 Opcode 2 (MUL): unsigned 8x8 shift-add, one multiplier bit per cycle LSB first, 8 EXEC cycles; result = full 16-bit product.
REQ-019 Opcode 3 (DIV): unsigned restoring division, one quotient bit per cycle, 8 EXEC cycles; result[15:8] = a/b, result[7:0] = a%b.
REQ-020 DIV with b=0: EXEC lasts 1 cycle; result = {8'hFF, a}; error=1.
REQ-021 Opcodes 4-15: EXEC lasts 1 cycle; result = 16'h0000; error=1.
REQ-022 After final EXEC cycle SHALL enter DONE; done=1 for exactly that one cycle; result and error updated on entry to DONE.
REQ-023 Latency from capture edge to done high: 2 cycles for 1-cycle ops, 9 cycles for MUL/DIV (b≠0).
REQ-024 From DONE: enable=0 -> IDLE; enable=1 -> RELEASE.
REQ-025 RELEASE: SHALL wait until enable=0, then go to IDLE; no new capture while in RELEASE (no retrigger on stale enable).
REQ-026 enable dropping during EXEC SHALL NOT abort the operation; it completes and pulses done.
REQ-027 result and error SHALL hold their values from DONE until the next DONE or reset.
REQ-028 error SHALL be 0 for every successful ADD, SUB, MUL, DIV.
REQ-029 Iteration counter SHALL be 4 bits, count 0-7, no wrap beyond 7 in EXEC.

Reset
REQ-030 reset=0 SHALL immediately (asynchronously) force state=IDLE, done=0, busy=0, error=0, result=16'h0000, counter and captured registers to 0.
REQ-031 reset asserted mid-EXEC SHALL discard the operation; no done pulse after reset release.
REQ-032 First capture after reset release SHALL require enable=1 sampled on a rising edge with reset=1.

Verification
REQ-033 ADD a=8'hFF b=8'h01, enable held until done -> done 2 cycles after capture, result=16'h0100, error=0, then RELEASE->IDLE when enable drops.
REQ-034 SUB a=8'h03 b=8'h05 -> result=16'hFFFE, error=0.
REQ-035 MUL a=8'hFF b=8'hFF -> busy for 9 cycles, done on 9th cycle after capture, result=16'hFE01; changing a/b mid-EXEC leaves result unchanged.
REQ-036 DIV a=8'd200 b=8'd7 -> result=16'h1C04 after 9 cycles; DIV a=8'h2A b=0 -> result=16'hFF2A, error=1, latency 2.
REQ-037 opcode 4'hF with enable=1 -> result=16'h0000, error=1, done one cycle; enable held high 5 extra cycles -> no second done.
REQ-038 MUL started, reset pulsed low on 4th EXEC cycle -> all outputs 0 immediately, state IDLE, no done afterward until new enable.

Source files
------------

// File: rtl/alu_datapath.sv
// Multi-cycle 8-bit ALU: add/sub in one cycle, shift-add mul and restoring div in eight.
// Ports: clk, reset (async low), enable/opcode/a/b in; done/result/error/busy out.
module alu_datapath #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [OP_W-1:0]  opcode,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic             busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXEC    = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);

  logic [1:0]      state;
  logic [3:0]      cnt;
  logic [OP_W-1:0] op_r;
  logic [7:0]      a_r;
  logic [7:0]      b_r;
  logic [15:0]     acc;
  logic [7:0]      rem;
  logic [7:0]      quo;

  logic [2:0]  bit_ix;
  logic [15:0] addend;
  logic [15:0] mul_sum;
  logic [8:0]  rem_sh;
  logic        ge;
  logic [8:0]  rem_sub;
  logic [7:0]  rem_n;
  logic [7:0]  quo_n;

  assign bit_ix  = cnt[2:0];
  assign addend  = b_r[bit_ix] ? (16'(a_r) << bit_ix) : 16'h0000;
  assign mul_sum = acc + addend;

  // dividend bits enter MSB first
  assign rem_sh  = {rem, a_r[3'd7 - bit_ix]};
  assign ge      = rem_sh >= {1'b0, b_r};
  assign rem_sub = rem_sh - {1'b0, b_r};
  assign rem_n   = ge ? rem_sub[7:0] : rem_sh[7:0];
  assign quo_n   = {quo[6:0], ge};

  assign done = (state == DONE);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      op_r   <= '0;
      a_r    <= 8'h00;
      b_r    <= 8'h00;
      acc    <= 16'h0000;
      rem    <= 8'h00;
      quo    <= 8'h00;
      result <= '0;
      error  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            op_r  <= opcode;
            a_r   <= a;
            b_r   <= b;
            cnt   <= 4'd0;
            acc   <= 16'h0000;
            rem   <= 8'h00;
            quo   <= 8'h00;
            state <= EXEC;
          end
        end
        EXEC: begin
          unique case (op_r)
            OP_ADD: begin
              result <= WIDTH'({1'b0, a_r} + {1'b0, b_r});
              error  <= 1'b0;
              state  <= DONE;
            end
            OP_SUB: begin
              result <= WIDTH'({8'h00, a_r} - {8'h00, b_r});
              error  <= 1'b0;
              state  <= DONE;
            end
            OP_MUL: begin
              if (cnt == 4'd7) begin
                result <= WIDTH'(mul_sum);
                error  <= 1'b0;
                state  <= DONE;
              end else begin
                acc <= mul_sum;
                cnt <= cnt + 4'd1;
              end
            end
            OP_DIV: begin
              if (b_r == 8'h00) begin
                result <= WIDTH'({8'hFF, a_r});
                error  <= 1'b1;
                state  <= DONE;
              end else if (cnt == 4'd7) begin
                result <= WIDTH'({quo_n, rem_n});
                error  <= 1'b0;
                state  <= DONE;
              end else begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt + 4'd1;
              end
            end
            default: begin
              result <= '0;
              error  <= 1'b1;
              state  <= DONE;
            end
          endcase
        end
        DONE: begin
          state <= enable ? RELEASE : IDLE;
        end
        RELEASE: begin
          if (!enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_datapath.sv
// Randomised self-checking bench for alu_datapath.
// Checks results, error flag, latency, handshake and reset against a model.
module tb_alu_datapath;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  opcode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        done;
  logic [15:0] result;
  logic        error;
  logic        busy;

  int n_tests;
  int n_fail;

  alu_datapath dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .done   (done),
    .result (result),
    .error  (error),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [7:0] av,
                       input logic [7:0] bv, output logic [15:0] res,
                       output logic err, output int lat);
    int ai;
    int bi;
    ai  = av;
    bi  = bv;
    err = 1'b0;
    lat = 2;
    case (op)
      4'd0: res = 16'(ai + bi);
      4'd1: res = 16'(ai - bi);
      4'd2: begin
        res = 16'(ai * bi);
        lat = 9;
      end
      4'd3: begin
        if (bi == 0) begin
          res = {8'hFF, av};
          err = 1'b1;
        end else begin
          res = {8'(ai / bi), 8'(ai % bi)};
          lat = 9;
        end
      end
      default: begin
        res = 16'h0000;
        err = 1'b1;
      end
    endcase
  endtask

  task automatic run_op(input logic [3:0] op, input logic [7:0] av,
                        input logic [7:0] bv, input bit drop_en);
    logic [15:0] er;
    logic        ee;
    int          lat;
    int          first;
    int          ndone;
    model(op, av, bv, er, ee, lat);
    @(negedge clk);
    enable = 1'b1;
    opcode = op;
    a      = av;
    b      = bv;
    @(posedge clk);
    #1;
    if (drop_en) enable = 1'b0;
    a      = 8'($urandom);
    b      = 8'($urandom);
    opcode = 4'($urandom);
    first  = 0;
    ndone  = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k <= lat) chk("busy_exec", busy, 1'b1);
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = k;
          chk("result", result, er);
          chk("error", error, ee);
        end
      end
    end
    chk("latency", first, lat);
    chk("done_count", ndone, 1);
    chk("result_hold", result, er);
    chk("error_hold", error, ee);
    if (!drop_en) begin
      chk("busy_release", busy, 1'b1);
      enable = 1'b0;
      @(negedge clk);
    end
    chk("busy_idle", busy, 1'b0);
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] bv;
    int         nd;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    enable  = 1'b0;
    opcode  = 4'h0;
    a       = 8'h00;
    b       = 8'h00;
    #12;
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_error", error, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    run_op(4'h0, 8'hFF, 8'h01, 1'b0);
    run_op(4'h1, 8'h03, 8'h05, 1'b0);
    run_op(4'h2, 8'hFF, 8'hFF, 1'b0);
    run_op(4'h3, 8'd200, 8'd7, 1'b0);
    run_op(4'h3, 8'h2A, 8'h00, 1'b0);
    run_op(4'hF, 8'h12, 8'h34, 1'b0);
    run_op(4'h2, 8'h00, 8'h9C, 1'b1);
    run_op(4'h3, 8'h05, 8'hFF, 1'b1);
    run_op(4'h3, 8'hFF, 8'h01, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 5));
      if (op > 4'd3) op = 4'($urandom_range(4, 15));
      bv = 8'($urandom);
      if ($urandom_range(0, 5) == 0) bv = 8'h00;
      run_op(op, 8'($urandom), bv, 1'($urandom));
    end

    // reset in the middle of a multiply
    @(negedge clk);
    enable = 1'b1;
    opcode = 4'h2;
    a      = 8'hA5;
    b      = 8'h3C;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_result", result, 16'h0000);
    chk("mid_rst_error", error, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("post_rst_quiet", nd, 0);
    run_op(4'h0, 8'h7F, 8'h80, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
